phase_accumulator_nco: RTL and testbench

//   Numerically controlled oscillator feeding sine_wavetable.phase. Once per sample_tick it adds a

---
 rtl/phase_accumulator_nco.sv | 126 ++++++++++++
 tb/tb_phase_accumulator_nco.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator_nco.sv
// Phase accumulator NCO with exponential glide toward a loaded increment and held hard-sync.
// Widths come from mypackage so the accumulator and the wavetable index stay in step.
package mypackage;
  localparam int PHASE_INDEX_BITS = 16;
  localparam int WAVETABLE_N = 256;
  localparam int PHASE_ACCUMULATOR_FRACTIONAL_BITS = PHASE_INDEX_BITS - $clog2(WAVETABLE_N);
  typedef logic [PHASE_INDEX_BITS-1:0] phase_index_type;
endpackage

module phase_accumulator_nco
  import mypackage::*;
#(
  parameter int GLIDE_SHIFT_BITS = 4,
  parameter bit GLIDE_LOCK       = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        enable,
  input  logic                        inc_valid,
  output logic                        inc_ready,
  input  logic [PHASE_INDEX_BITS-1:0] inc_data,
  input  logic [GLIDE_SHIFT_BITS-1:0] glide_shift,
  input  logic                        sync,
  output phase_index_type             phase,
  output logic                        phase_valid,
  output logic                        wrap
);

  localparam int PW = PHASE_INDEX_BITS;

  typedef enum logic {IDLE, GLIDING} state_t;

  // A shift that rounds a nonzero difference to zero is forced to a unit step so glides always land.
  function automatic logic signed [PW:0] glide_step(input logic signed [PW:0] diff,
                                                    input logic [GLIDE_SHIFT_BITS-1:0] shift);
    logic signed [PW:0] step;
    step = diff >>> shift;
    if (step == '0 && diff != '0) begin
      step = diff[PW] ? '1 : {{PW{1'b0}}, 1'b1};
    end
    return step;
  endfunction

  state_t          state_q, state_d;
  phase_index_type phase_q, phase_d;
  phase_index_type cur_inc_q, cur_inc_d;
  phase_index_type target_q, target_d;
  logic            sync_pend_q, sync_pend_d;
  logic            phase_valid_q, phase_valid_d;
  logic            wrap_q, wrap_d;
  logic            ready_q;

  logic               tick, xfer, sync_now, carry;
  phase_index_type    sum;
  logic signed [PW:0] diff, step, inc_wide;

  assign tick     = sample_tick && enable;
  assign xfer     = inc_valid && inc_ready;
  assign sync_now = sync_pend_q || sync;
  assign {carry, sum} = {1'b0, phase_q} + {1'b0, cur_inc_q};
  assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, cur_inc_q});
  assign step     = glide_step(diff, glide_shift);
  assign inc_wide = $signed({1'b0, cur_inc_q}) + step;

  assign inc_ready   = ready_q && !(GLIDE_LOCK && (state_q == GLIDING));
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cur_inc_d     = cur_inc_q;
    target_d      = xfer ? inc_data : target_q;
    sync_pend_d   = sync_now;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    if (tick) begin
      phase_valid_d = 1'b1;
      phase_d       = sync_now ? '0 : sum;
      wrap_d        = sync_now || carry;
      sync_pend_d   = 1'b0;
    end

    // The glide always works from the pre-transfer target; a same-edge load applies next tick.
    case (state_q)
      IDLE: begin
        if (target_q != cur_inc_q) state_d = GLIDING;
      end
      GLIDING: begin
        if (tick) begin
          cur_inc_d = inc_wide[PW-1:0];
          if (inc_wide == $signed({1'b0, target_q})) state_d = IDLE;
        end else if (cur_inc_q == target_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      cur_inc_q     <= '0;
      target_q      <= '0;
      sync_pend_q   <= 1'b0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cur_inc_q     <= cur_inc_d;
      target_q      <= target_d;
      sync_pend_q   <= sync_pend_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
      ready_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_accumulator_nco.sv
// Bench for phase_accumulator_nco: directed scenarios plus randomized traffic against an arithmetic model.
module tb_phase_accumulator_nco;
  import mypackage::*;

  localparam int PW  = PHASE_INDEX_BITS;
  localparam int MOD = 1 << PW;

  logic            clk = 1'b0;
  logic            rst, tick, en, iv, sync_r;
  phase_index_type idata;
  logic [3:0]      gs;
  logic            ready0, pv0, wrap0, ready1, pv1, wrap1;
  phase_index_type phase0, phase1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the unlocked instance
  int m_phase, m_inc, m_target;
  bit m_pend, m_glide, m_ready, m_pv, m_wrap;

  always #5 clk = ~clk;

  phase_accumulator_nco #(.GLIDE_SHIFT_BITS(4), .GLIDE_LOCK(1'b0)) dut0 (
    .clock(clk), .reset(rst), .sample_tick(tick), .enable(en), .inc_valid(iv),
    .inc_ready(ready0), .inc_data(idata), .glide_shift(gs), .sync(sync_r),
    .phase(phase0), .phase_valid(pv0), .wrap(wrap0));

  phase_accumulator_nco #(.GLIDE_SHIFT_BITS(4), .GLIDE_LOCK(1'b1)) dut1 (
    .clock(clk), .reset(rst), .sample_tick(tick), .enable(en), .inc_valid(iv),
    .inc_ready(ready1), .inc_data(idata), .glide_shift(gs), .sync(sync_r),
    .phase(phase1), .phase_valid(pv1), .wrap(wrap1));

  task automatic model_reset();
    m_phase = 0; m_inc = 0; m_target = 0;
    m_pend = 0; m_glide = 0; m_ready = 0; m_pv = 0; m_wrap = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs present before the edge.
  task automatic step();
    int  sum, d, s, q, nphase, ninc;
    bit  t, x, npend, nglide, npv, nwrap;
    t = tick && en;
    x = iv && m_ready;
    nphase = m_phase; ninc = m_inc; npend = m_pend || sync_r;
    nglide = m_glide; npv = 0; nwrap = 0;
    if (t) begin
      sum = m_phase + m_inc;
      npv = 1; npend = 0;
      if (m_pend || sync_r) begin nphase = 0; nwrap = 1; end
      else begin nphase = sum % MOD; nwrap = (sum >= MOD); end
    end
    if (m_glide) begin
      if (t) begin
        d = m_target - m_inc;
        q = 1 << gs;
        s = (d >= 0) ? d / q : -((-d + q - 1) / q);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        ninc = m_inc + s;
        nglide = (ninc != m_target);
      end else begin
        nglide = (m_inc != m_target);
      end
    end else begin
      nglide = (m_target != m_inc);
    end
    @(posedge clk);
    #1;
    m_phase = nphase; m_inc = ninc; m_pend = npend; m_glide = nglide;
    m_pv = npv; m_wrap = nwrap;
    if (x) m_target = int'(idata);
    m_ready = 1;
  endtask

  task automatic do_reset();
    tick = 0; iv = 0; sync_r = 0; en = 1;
    #2 rst = 1;
    #3 rst = 0;
    model_reset();
    step();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (phase0 !== '0 || pv0 !== 1'b0 || wrap0 !== 1'b0 || ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: phase=%h pv=%b wrap=%b ready=%b, required 0/0/0/0", phase0, pv0, wrap0, ready0);
    end
    #11 rst = 0;
    model_reset();
    step();
    n_cmp++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: ready0=%b ready1=%b, required 1/1", ready0, ready1);
    end
    gs = 4'd0; iv = 1; idata = 16'h0100;
    step();
    iv = 0;
    step(); step();
    tick = 1;
    step(); step(); step();
    tick = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if (phase0 !== '0 || pv0 !== 1'b0 || wrap0 !== 1'b0 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: phase=%h pv=%b wrap=%b ready0=%b ready1=%b, required all 0", phase0, pv0, wrap0, ready0, ready1);
    end
    #2 rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_before_edge: ready=%b, required 0", ready0);
    end
    step();
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after_edge: ready=%b, required 1", ready0);
    end
  endtask

  task automatic test_immediate_load();
    int exp_p[4] = '{0, 'h100, 'h200, 'h300};
    do_reset();
    gs = 4'd0; iv = 1; idata = 16'h0100;
    step();
    iv = 0;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      tick = 1;
      step();
      n_cmp++;
      if (phase0 !== phase_index_type'(exp_p[k]) || pv0 !== 1'b1 || phase0 !== phase_index_type'(m_phase)) begin
        n_err++;
        $display("FAIL load_tick%0d: phase=%h pv=%b, required phase=%h pv=1", k, phase0, pv0, exp_p[k]);
      end
      tick = 0;
      step();
      n_cmp++;
      if (pv0 !== 1'b0 || phase0 !== phase_index_type'(exp_p[k])) begin
        n_err++;
        $display("FAIL load_hold%0d: phase=%h pv=%b, required phase=%h pv=0", k, phase0, pv0, exp_p[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_p[6] = '{0, 'h4000, 'h8000, 'hC000, 0, 'h4000};
    bit exp_w[6] = '{0, 0, 0, 0, 1, 0};
    do_reset();
    gs = 4'd0; iv = 1; idata = phase_index_type'(1 << (PW - 2));
    step();
    iv = 0;
    step(); step();
    tick = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (phase0 !== phase_index_type'(exp_p[k]) || wrap0 !== exp_w[k] || pv0 !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_tick%0d: phase=%h wrap=%b pv=%b, required phase=%h wrap=%b pv=1",
                 k, phase0, wrap0, pv0, exp_p[k], exp_w[k]);
      end
    end
    tick = 0;
    step();
    n_cmp++;
    if (pv0 !== 1'b0 || wrap0 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_idle: pv=%b wrap=%b, required 0/0", pv0, wrap0);
    end
  endtask

  task automatic test_glide();
    int exp_p[6] = '{0, 8, 20, 34, 49, 65};
    do_reset();
    gs = 4'd1; iv = 1; idata = 16'd16;
    step();
    iv = 0;
    step(); step();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (ready1 !== (k == 5)) begin
        n_err++;
        $display("FAIL glide_lock_ready%0d: ready=%b, required %b", k, ready1, (k == 5));
      end
      tick = 1;
      step();
      n_cmp++;
      if (phase0 !== phase_index_type'(exp_p[k]) || phase1 !== phase_index_type'(exp_p[k]) || pv0 !== 1'b1) begin
        n_err++;
        $display("FAIL glide_tick%0d: phase0=%h phase1=%h pv=%b, required phase=%h pv=1",
                 k, phase0, phase1, pv0, exp_p[k]);
      end
      tick = 0;
      step();
    end
  endtask

  task automatic test_sync();
    sync_r = 1;
    step();
    sync_r = 0; en = 0; tick = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (phase0 !== 16'd65 || pv0 !== 1'b0 || wrap0 !== 1'b0) begin
        n_err++;
        $display("FAIL sync_frozen%0d: phase=%h pv=%b wrap=%b, required phase=0041 pv=0 wrap=0", k, phase0, pv0, wrap0);
      end
    end
    en = 1;
    step();
    n_cmp++;
    if (phase0 !== '0 || wrap0 !== 1'b1 || pv0 !== 1'b1) begin
      n_err++;
      $display("FAIL sync_apply: phase=%h wrap=%b pv=%b, required phase=0000 wrap=1 pv=1", phase0, wrap0, pv0);
    end
    tick = 0;
    step();
    tick = 1;
    step();
    n_cmp++;
    if (phase0 !== 16'd16 || wrap0 !== 1'b0) begin
      n_err++;
      $display("FAIL sync_cleared: phase=%h wrap=%b, required phase=0010 wrap=0", phase0, wrap0);
    end
    tick = 0;
    step();
  endtask

  task automatic test_glide_lock();
    int exp_p[5] = '{0, 8, 20, 34, 49};
    do_reset();
    gs = 4'd1; iv = 1; idata = 16'd16;
    step();
    iv = 0;
    step(); step();
    iv = 1; idata = 16'd100;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (ready1 !== 1'b0) begin
        n_err++;
        $display("FAIL lock_stall%0d: ready=%b, required 0", k, ready1);
      end
      tick = 1;
      step();
      n_cmp++;
      if (phase1 !== phase_index_type'(exp_p[k]) || pv1 !== 1'b1) begin
        n_err++;
        $display("FAIL lock_tick%0d: phase=%h pv=%b, required phase=%h pv=1", k, phase1, pv1, exp_p[k]);
      end
      if (k < 4) begin
        tick = 0;
        step();
      end
    end
    n_cmp++;
    if (ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL lock_release: ready=%b, required 1", ready1);
    end
    step();
    n_cmp++;
    if (phase1 !== 16'd65) begin
      n_err++;
      $display("FAIL lock_same_edge: phase=%h, required 0041", phase1);
    end
    iv = 0; tick = 0;
    step();
    tick = 1;
    step();
    n_cmp++;
    if (phase1 !== 16'd81) begin
      n_err++;
      $display("FAIL lock_old_target: phase=%h, required 0051", phase1);
    end
    step();
    n_cmp++;
    if (phase1 !== 16'd139) begin
      n_err++;
      $display("FAIL lock_new_target: phase=%h, required 008b", phase1);
    end
    tick = 0;
    step();
  endtask

  task automatic test_reset_midglide();
    do_reset();
    gs = 4'd3; iv = 1; idata = 16'h1000;
    step();
    iv = 0;
    step(); step();
    tick = 1;
    step(); step(); step();
    tick = 0; sync_r = 1;
    step();
    sync_r = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if (phase0 !== '0 || wrap0 !== 1'b0 || ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL midglide_reset: phase=%h wrap=%b ready=%b, required 0/0/0", phase0, wrap0, ready0);
    end
    #2 rst = 0;
    model_reset();
    step();
    tick = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (phase0 !== '0 || wrap0 !== 1'b0 || pv0 !== 1'b1) begin
        n_err++;
        $display("FAIL midglide_no_replay%0d: phase=%h wrap=%b pv=%b, required 0000/0/1", k, phase0, wrap0, pv0);
      end
    end
    tick = 0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick   = ($urandom_range(0, 2) == 0);
      en     = ($urandom_range(0, 7) != 0);
      iv     = ($urandom_range(0, 9) == 0);
      idata  = phase_index_type'($urandom);
      gs     = 4'($urandom_range(0, 5));
      sync_r = ($urandom_range(0, 24) == 0);
      step();
      n_cmp++;
      if (phase0 !== phase_index_type'(m_phase) || pv0 !== m_pv || wrap0 !== m_wrap || ready0 !== m_ready) begin
        n_err++;
        $display("FAIL random%0d: phase=%h pv=%b wrap=%b ready=%b, required phase=%h pv=%b wrap=%b ready=%b",
                 c, phase0, pv0, wrap0, ready0, phase_index_type'(m_phase), m_pv, m_wrap, m_ready);
      end
    end
    tick = 0; iv = 0; sync_r = 0; en = 1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; tick = 0; en = 1; iv = 0; sync_r = 0; idata = '0; gs = 4'd0;
    model_reset();
    test_reset();
    test_immediate_load();
    test_wrap();
    test_glide();
    test_sync();
    test_glide_lock();
    test_reset_midglide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
